encoder8_to_3_seq: RTL

- Reverse direction of the team's 3-to-8 decoder.
- Accepts an 8-bit multi-hot vector through a valid/ready handshake.
- Emits the 3-bit binary code of every set bit, one code per accepted output beat, lowest index first.
- Used to turn decoded request/enable lines back into index streams for downstream sequencing logic.

---
 rtl/enc_pkg.sv | 22 ++
 rtl/encoder8_to_3_seq_if.sv | 26 ++
 rtl/ffs_enc.sv | 25 ++
 rtl/encoder8_to_3_seq.sv | 101 ++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared constants, FSM state type and helper for the 8-to-3 sequential encoder.
package enc_pkg;

  localparam int unsigned N = 8;
  localparam int unsigned W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [N-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < int'(N); i++) begin
      cnt += int'(v[i]);
    end
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/encoder8_to_3_seq_if.sv
// Input vector handshake and output code stream of the sequential encoder.
interface encoder8_to_3_seq_if;
  import enc_pkg::*;

  logic [N-1:0] w;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_code;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         out_zero;

  // Producer of vectors / consumer of codes.
  modport master (
    output w, in_valid, out_ready,
    input  in_ready, out_code, out_valid, out_last, out_zero
  );

  // Encoder side.
  modport slave (
    input  w, in_valid, out_ready,
    output in_ready, out_code, out_valid, out_last, out_zero
  );

endinterface

// File: rtl/ffs_enc.sv
// Combinational find-first-set: index of the lowest (or highest) set bit; 0 when none set.
module ffs_enc #(
  parameter int unsigned N         = 8,
  parameter int unsigned W         = 3,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx
);

  // Last match in loop order wins, so scan from the non-preferred end.
  always_comb begin
    o_idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < int'(N); i++) begin
        if (i_vec[i]) o_idx = W'(i);
      end
    end else begin
      for (int i = int'(N) - 1; i >= 0; i--) begin
        if (i_vec[i]) o_idx = W'(i);
      end
    end
  end

endmodule

// File: rtl/encoder8_to_3_seq.sv
// Sequential 8-to-3 encoder: accepts a multi-hot vector and emits one binary code per set bit.
// An all-zero vector yields a single beat flagged out_zero.
// Build option: define ENC_MSB_FIRST_EN to emit codes highest index first.
module encoder8_to_3_seq
  import enc_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  encoder8_to_3_seq_if.slave        bus
);

`ifdef ENC_MSB_FIRST_EN
  localparam bit MsbFirst = 1'b1;
`else
  localparam bit MsbFirst = 1'b0;
`endif

  state_e       r_state;
  logic [N-1:0] r_pending;
  logic         r_out_valid;
  logic [W-1:0] r_out_code;
  logic         r_out_last;
  logic         r_out_zero;

  logic         w_accept;
  logic         w_take;
  logic [N-1:0] w_clear_mask;
  logic [N-1:0] w_next_pending;
  logic [N-1:0] w_scan_src;
  logic [W-1:0] w_scan_code;

  assign bus.in_ready  = (r_state == IDLE) & en;
  assign bus.out_valid = r_out_valid;
  assign bus.out_code  = r_out_code;
  assign bus.out_last  = r_out_last;
  assign bus.out_zero  = r_out_zero;

  assign w_accept = bus.in_valid & bus.in_ready;
  assign w_take   = r_out_valid & bus.out_ready;

  // Pending bits left after the current beat is taken; scan source is the new vector when idle.
  always_comb begin
    w_clear_mask             = '0;
    w_clear_mask[r_out_code] = 1'b1;
    w_next_pending           = r_pending & ~w_clear_mask;
    w_scan_src               = (r_state == IDLE) ? bus.w : w_next_pending;
  end

  ffs_enc #(
    .N        (N),
    .W        (W),
    .MSB_FIRST(MsbFirst)
  ) u_ffs (
    .i_vec(w_scan_src),
    .o_idx(w_scan_code)
  );

  // FSM with registered outputs: load on accept, step one set bit per taken beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_out_valid <= 1'b0;
      r_out_code  <= '0;
      r_out_last  <= 1'b0;
      r_out_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state     <= DRAIN;
            r_pending   <= bus.w;
            r_out_valid <= 1'b1;
            r_out_code  <= w_scan_code;
            r_out_last  <= (bus.w == '0) | is_onehot(bus.w);
            r_out_zero  <= (bus.w == '0);
          end
        end
        DRAIN: begin
          if (w_take) begin
            if (r_out_last) begin
              r_state     <= IDLE;
              r_pending   <= '0;
              r_out_valid <= 1'b0;
              r_out_code  <= '0;
              r_out_last  <= 1'b0;
              r_out_zero  <= 1'b0;
            end else begin
              r_pending  <= w_next_pending;
              r_out_code <= w_scan_code;
              r_out_last <= is_onehot(w_next_pending);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
